isqrt_pipe_bp: RTL and testbench

ISQRT_PIPE_BP -- requirements
Module: isqrt_pipe_bp

---
 rtl/isqrt_pkg.sv | 42 ++++
 rtl/isqrt_step_comb.sv | 28 ++
 rtl/isqrt_pipe_bp.sv | 130 +++++++++++++
 tb/tb_isqrt_pipe_bp.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared arithmetic for the pipelined integer square root.
// Holds the result-width helpers and one restoring-algorithm slice,
// so the datapath and anything else needing the same step agree exactly.
package isqrt_pkg;

  // Width of the root output for a W-bit radicand.
  function automatic int y_width(input int w);
    return w / 2;
  endfunction

  // Width of the remainder output for a W-bit radicand.
  function automatic int r_width(input int w);
    return w / 2 + 1;
  endfunction

  // Partial state carried between slices, held at the widest supported width.
  typedef struct packed {
    logic [63:0] rem;
    logic [63:0] y;
  } step_t;

  // One restoring slice: trial-subtract (y | m) and shift the root right.
  // idx counts slices from the most significant bit pair (idx 0 uses m = 1 << (w-2)).
  function automatic step_t isqrt_step(input logic [63:0] rem,
                                       input logic [63:0] y,
                                       input int          w,
                                       input int          idx);
    logic [63:0] m;
    logic [63:0] b;
    step_t       s;
    m     = 64'd1 << (w - 2 - 2 * idx);
    b     = y | m;
    s.y   = y >> 1;
    s.rem = rem;
    if (rem >= b) begin
      s.rem = rem - b;
      s.y   = s.y | m;
    end
    return s;
  endfunction

endpackage

// File: rtl/isqrt_step_comb.sv
// One combinational restoring-sqrt slice at a fixed bit position IDX.
// Latency: zero, purely combinational.
// Backpressure: none; the enclosing pipeline stage decides when to register.
module isqrt_step_comb
  import isqrt_pkg::*;
#(
  parameter int W   = 32,
  parameter int IDX = 0
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] y_in,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] y_out
);

  step_t res;

  assign res     = isqrt_step(64'(rem_in), 64'(y_in), W, IDX);
  assign rem_out = res.rem[W-1:0];
  assign y_out   = res.y[W-1:0];

  // The step works at 64 bits; above W the results are always zero.
  if (W < 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{res.rem[63:W], res.y[63:W]};
  end

endmodule

// File: rtl/isqrt_pipe_bp.sv
// Pipelined floor(sqrt(x)) with remainder and pass-through tag, valid/ready on both sides.
// Latency: N_STAGES register stages from input transfer to y_vld.
// Backpressure: per-stage skid-free hold; empty stages fill even when the output stalls.
module isqrt_pipe_bp
  import isqrt_pkg::*;
#(
  parameter int W        = 32,
  parameter int N_STAGES = 4,
  parameter int TAG_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_vld,
  output logic                    x_rdy,
  input  logic [W-1:0]            x,
  input  logic [TAG_W-1:0]        x_tag,
  output logic                    y_vld,
  input  logic                    y_rdy,
  output logic [y_width(W)-1:0]   y,
  output logic [r_width(W)-1:0]   r,
  output logic [TAG_W-1:0]        y_tag
);

  localparam int YW  = y_width(W);
  localparam int RW  = r_width(W);
  localparam int SPS = W / (2 * N_STAGES);

  // Reject parameter sets the slice grouping cannot honour.
  if ((W % 2) != 0 || W < 4 || W > 64) begin : g_bad_w
    $fatal(1, "isqrt_pipe_bp: W must be even and within 4..64");
  end
  if (N_STAGES < 1 || ((W / 2) % N_STAGES) != 0) begin : g_bad_n
    $fatal(1, "isqrt_pipe_bp: W/2 must be divisible by N_STAGES");
  end

  logic [N_STAGES-1:0] st_vld;
  logic [N_STAGES-1:0] load;
  logic [N_STAGES-1:0] in_vld;
  logic [W-1:0]        st_rem  [N_STAGES];
  logic [W-1:0]        st_y    [N_STAGES];
  logic [TAG_W-1:0]    st_tag  [N_STAGES];
  logic [W-1:0]        nxt_rem [N_STAGES];
  logic [W-1:0]        nxt_y   [N_STAGES];
  logic [TAG_W-1:0]    in_tag  [N_STAGES];

  // Per-stage combinational slice chains feeding each stage register.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [W-1:0] c_rem [SPS+1];
    logic [W-1:0] c_y   [SPS+1];

    if (k == 0) begin : g_head
      assign c_rem[0] = x;
      assign c_y[0]   = '0;
    end else begin : g_body
      assign c_rem[0] = st_rem[k-1];
      assign c_y[0]   = st_y[k-1];
    end

    for (genvar j = 0; j < SPS; j++) begin : g_slice
      isqrt_step_comb #(
        .W   (W),
        .IDX (k * SPS + j)
      ) u_step (
        .rem_in  (c_rem[j]),
        .y_in    (c_y[j]),
        .rem_out (c_rem[j+1]),
        .y_out   (c_y[j+1])
      );
    end

    assign nxt_rem[k] = c_rem[SPS];
    assign nxt_y[k]   = c_y[SPS];
  end

  // Load enables ripple from the output back: a stage may load if it is empty
  // or everything downstream of it can move, which compresses bubbles.
  always_comb begin
    logic chain;
    load  = '0;
    chain = y_rdy;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      chain   = !st_vld[k] || chain;
      load[k] = chain;
    end
  end

  // Valid and tag offered to each stage by its upstream neighbour.
  always_comb begin
    in_vld    = '0;
    in_vld[0] = x_vld;
    in_tag[0] = x_tag;
    for (int k = 1; k < N_STAGES; k++) begin
      in_vld[k] = st_vld[k-1];
      in_tag[k] = st_tag[k-1];
    end
  end

  // Stage occupancy; the only state cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_vld <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (load[k]) st_vld[k] <= in_vld[k];
      end
    end
  end

  // Stage payload; captured only when a real sample moves in, otherwise held.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_STAGES; k++) begin
      if (load[k] && in_vld[k]) begin
        st_rem[k] <= nxt_rem[k];
        st_y[k]   <= nxt_y[k];
        st_tag[k] <= in_tag[k];
      end
    end
  end

  assign x_rdy = load[0];
  assign y_vld = st_vld[N_STAGES-1];
  assign y     = st_y[N_STAGES-1][YW-1:0];
  assign r     = st_rem[N_STAGES-1][RW-1:0];
  assign y_tag = st_tag[N_STAGES-1];

  // After all slices the root fits in W/2 bits and the remainder in W/2+1.
  logic unused_hi;
  assign unused_hi = ^{st_rem[N_STAGES-1][W-1:RW], st_y[N_STAGES-1][W-1:YW]};

endmodule

// File: tb/tb_isqrt_pipe_bp.sv
// Self-checking bench for isqrt_pipe_bp: default 32-bit instance plus a 16-bit/2-stage instance.
// Expected roots come from an arithmetic binary-search model; a queue tracks acceptance order.
// All inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
module tb_isqrt_pipe_bp;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        x_vld, x_rdy, y_vld, y_rdy;
  logic [31:0] x;
  logic [3:0]  x_tag, y_tag;
  logic [15:0] y;
  logic [16:0] r;

  logic        x16_vld, x16_rdy, y16_vld, y16_rdy;
  logic [15:0] x16;
  logic [3:0]  x16_tag, y16_tag;
  logic [7:0]  y16;
  logic [8:0]  r16;

  isqrt_pipe_bp dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x_rdy(x_rdy), .x(x), .x_tag(x_tag),
    .y_vld(y_vld), .y_rdy(y_rdy), .y(y), .r(r), .y_tag(y_tag)
  );

  isqrt_pipe_bp #(.W(16), .N_STAGES(2), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .x_vld(x16_vld), .x_rdy(x16_rdy), .x(x16), .x_tag(x16_tag),
    .y_vld(y16_vld), .y_rdy(y16_rdy), .y(y16), .r(r16), .y_tag(y16_tag)
  );

  typedef struct {
    logic [15:0] y;
    logic [16:0] r;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          check_lat = 0;
  bit          in_fire, out_fire;
  logic [15:0] exp_y;
  logic [16:0] exp_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // floor(sqrt(xv)) by binary search on the root; remainder by subtraction
  function automatic void ref_isqrt(input logic [31:0] xv, output logic [15:0] yv, output logic [16:0] rv);
    longint unsigned lo, hi, mid, xx;
    xx = 64'(xv);
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= xx) lo = mid;
      else hi = mid;
    end
    yv = lo[15:0];
    rv = 17'(xx - lo * lo);
  endfunction

  task automatic offer(input logic [31:0] xv, input logic [3:0] tv);
    x     = xv;
    x_tag = tv;
    ref_isqrt(xv, exp_y, exp_r);
  endtask

  // One clock: sample handshakes, score any output, record any input, advance
  task automatic cycle();
    exp_t e;
    #1;
    in_fire  = x_vld && x_rdy;
    out_fire = y_vld && y_rdy;
    if (out_fire) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL underflow: output transfer tag %0d with nothing outstanding, want no transfer", y_tag);
      end else begin
        e = sb.pop_front();
        n_total++;
        if ({y, r, y_tag} !== {e.y, e.r, e.tag})
          $display("FAIL out_data: got y=%0d r=%0d tag=%0d, want y=%0d r=%0d tag=%0d", y, r, y_tag, e.y, e.r, e.tag);
        else n_pass++;
        n_total++;
        if (longint'(r) > 2 * longint'(y))
          $display("FAIL r_bound: got r=%0d with y=%0d, want r<=2*y", r, y);
        else n_pass++;
        if (check_lat) begin
          n_total++;
          if ((cyc - e.acc) !== N)
            $display("FAIL latency: got %0d cycles, want %0d", cyc - e.acc, N);
          else n_pass++;
        end
      end
    end
    if (in_fire) sb.push_back('{y: exp_y, r: exp_r, tag: x_tag, acc: cyc});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int k = 0;
    x_vld = 1'b0;
    y_rdy = 1'b1;
    while (sb.size() != 0 && k < 40) begin
      cycle();
      k++;
    end
    n_total++;
    if (sb.size() !== 0) $display("FAIL drain: got %0d samples left, want 0", sb.size());
    else n_pass++;
    n_total++;
    if (y_vld !== 1'b0) $display("FAIL drain_vld: got y_vld=%b, want 0", y_vld);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; x_vld = 1'b0; y_rdy = 1'b0; x = '0; x_tag = '0;
    x16_vld = 1'b0; y16_rdy = 1'b0; x16 = '0; x16_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (y_vld !== 1'b0) $display("FAIL reset_vld: got %b, want 0", y_vld); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (y_vld !== 1'b0 || x_rdy !== 1'b1)
      $display("FAIL reset_release: got y_vld=%b x_rdy=%b, want 0 1", y_vld, x_rdy);
    else n_pass++;
    n_total++;
    if (y16_vld !== 1'b0 || x16_rdy !== 1'b1)
      $display("FAIL reset_release16: got y_vld=%b x_rdy=%b, want 0 1", y16_vld, x16_rdy);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] xs [4] = '{32'd0, 32'd99, 32'd1000000, 32'hFFFF_FFFF};
    logic [15:0] ys [4] = '{16'd0, 16'd9, 16'd1000, 16'hFFFF};
    logic [16:0] rs [4] = '{17'd0, 17'd18, 17'd0, 17'h1FFFE};
    check_lat = 1'b1;
    y_rdy     = 1'b1;
    x_vld     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x     = xs[i];
      x_tag = 4'(i + 1);
      exp_y = ys[i];
      exp_r = rs[i];
      cycle();
    end
    drain();
    check_lat = 1'b0;
  endtask

  task automatic test_w16();
    logic [15:0] xv [2] = '{16'hFFFF, 16'h4000};
    logic [7:0]  ye [2] = '{8'hFF, 8'h80};
    logic [8:0]  re [2] = '{9'h1FE, 9'h000};
    int k;
    y16_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x16     = xv[i];
      x16_tag = 4'(i + 5);
      x16_vld = 1'b1;
      #1;
      n_total++;
      if (x16_rdy !== 1'b1) $display("FAIL w16_rdy: got %b, want 1", x16_rdy); else n_pass++;
      @(posedge clk);
      #1;
      x16_vld = 1'b0;
      k = 1;
      while (!y16_vld && k < 10) begin
        @(posedge clk);
        #1;
        k++;
      end
      n_total++;
      if (k !== 2) $display("FAIL w16_latency: got %0d cycles, want 2", k); else n_pass++;
      n_total++;
      if ({y16, r16, y16_tag} !== {ye[i], re[i], 4'(i + 5)})
        $display("FAIL w16_data: got y=%h r=%h tag=%0d, want y=%h r=%h tag=%0d", y16, r16, y16_tag, ye[i], re[i], i + 5);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int fires = 0;
    y_rdy = 1'b0;
    x_vld = 1'b1;
    while (sb.size() < 4 && k < 20) begin
      offer($urandom, 4'(sb.size() + 1));
      cycle();
      k++;
    end
    n_total++;
    if (sb.size() !== 4) $display("FAIL stall_fill: got %0d accepted, want 4", sb.size()); else n_pass++;
    offer($urandom, 4'd5);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (x_rdy !== 1'b0) $display("FAIL stall_xrdy: got %b, want 0", x_rdy); else n_pass++;
      n_total++;
      if (y_vld !== 1'b1 || y_tag !== 4'd1)
        $display("FAIL stall_head: got y_vld=%b tag=%0d, want 1 1", y_vld, y_tag);
      else n_pass++;
      n_total++;
      if ({y, r} !== {sb[0].y, sb[0].r})
        $display("FAIL stall_hold: got y=%0d r=%0d, want y=%0d r=%0d", y, r, sb[0].y, sb[0].r);
      else n_pass++;
      cycle();
    end
    x_vld = 1'b0;
    y_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (out_fire) fires++;
    end
    n_total++;
    if (fires !== 4 || sb.size() !== 0)
      $display("FAIL stall_release: got %0d transfers, %0d left, want 4 and 0", fires, sb.size());
    else n_pass++;
  endtask

  task automatic test_bubble();
    bit pat [10] = '{1, 0, 1, 0, 1, 1, 1, 1, 0, 1};
    y_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x_vld = pat[i];
      offer($urandom, 4'($urandom));
      #1;
      n_total++;
      if (x_rdy !== (sb.size() < N))
        $display("FAIL bubble_xrdy: step %0d occupancy %0d got x_rdy=%b, want %b", i, sb.size(), x_rdy, sb.size() < N);
      else n_pass++;
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    int k = 0;
    y_rdy = 1'b0;
    x_vld = 1'b1;
    while (sb.size() < 3 && k < 10) begin
      offer($urandom, 4'(sb.size() + 8));
      cycle();
      k++;
    end
    x_vld = 1'b0;
    cycle();
    n_total++;
    if (y_vld !== 1'b1) $display("FAIL inflight_vld: got %b, want 1", y_vld); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (y_vld !== 1'b0 || x_rdy !== 1'b1)
      $display("FAIL reset_async: got y_vld=%b x_rdy=%b, want 0 1", y_vld, x_rdy);
    else n_pass++;
    sb.delete();
    #2;
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    y_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_total++;
      if (y_vld !== 1'b0) $display("FAIL post_reset_idle: got y_vld=%b, want 0", y_vld); else n_pass++;
    end
    check_lat = 1'b1;
    x_vld = 1'b1;
    offer(32'd144, 4'hA);
    cycle();
    drain();
    check_lat = 1'b0;
  endtask

  task automatic test_random();
    int unsigned v;
    logic [31:0] xv;
    for (int i = 0; i < 3000; i++) begin
      x_vld = ($urandom % 4) != 0;
      y_rdy = ($urandom % 3) != 0;
      v = $urandom % 65536;
      case ($urandom % 8)
        0:       xv = 32'd0;
        1:       xv = 32'hFFFF_FFFF;
        2:       xv = v * v;
        3:       xv = (v * v) - ((v != 0) ? 32'd1 : 32'd0);
        default: xv = $urandom;
      endcase
      offer(xv, 4'($urandom));
      cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_w16();
    test_stall();
    test_bubble();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
